// File: rtl/iagc_pkg.sv
// rtl/iagc_pkg.sv - shared IAGC state codes, status codes and DAC init table
package iagc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } dacState_t;

  typedef enum logic [2:0] {
    IAGC_INIT    = 3'd0,
    IAGC_ACQUIRE = 3'd1,
    IAGC_TRACK   = 3'd2,
    IAGC_HOLD    = 3'd3,
    IAGC_FAULT   = 3'd4
  } iagcStatus_t;

  localparam int DAC_INIT_COUNT = 3;

  // power-up, full-scale, control
  localparam logic [15:0] DAC_INIT_WORDS [DAC_INIT_COUNT] = '{16'h2001, 16'h3FFF, 16'h4A55};

  function automatic logic [15:0] dacInitWord(input int idx);
    if (idx >= 0 && idx < DAC_INIT_COUNT) begin
      return DAC_INIT_WORDS[idx];
    end
    return 16'h0000;
  endfunction

endpackage

// File: rtl/iagc_dac_init_if.sv
// rtl/iagc_dac_init_if.sv - 3-wire DAC serial link (chip select, clock, data)
interface iagc_dac_init_if;
  logic csN;
  logic sclk;
  logic mosi;

  modport master (output csN, sclk, mosi);
  modport slave  (input  csN, sclk, mosi);
endinterface

// File: rtl/iagc_spi_tx.sv
// rtl/iagc_spi_tx.sv - single-word mode-0 MSB-first serialiser with registered sclk/mosi
module iagc_spi_tx #(
  parameter int WORD_WIDTH = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

  logic                  active;
  logic                  phase;
  logic [DIV_W-1:0]      divCnt;
  logic [BIT_W-1:0]      bitCnt;
  logic [WORD_WIDTH-1:0] shiftReg;
  logic                  divLast;
  logic                  bitEnd;

  assign divLast = (divCnt == DIV_LAST);
  assign bitEnd  = active && phase && divLast;
  assign done    = bitEnd && (bitCnt == BIT_LAST);
  assign busy    = active;

  // sclk/mosi are registered copies of the internal phase, one clock behind it
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      active   <= 1'b0;
      phase    <= 1'b0;
      divCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      sclk <= active && phase;
      mosi <= active && shiftReg[WORD_WIDTH-1];
      if (load) begin
        active   <= 1'b1;
        phase    <= 1'b0;
        divCnt   <= '0;
        bitCnt   <= '0;
        shiftReg <= word;
      end else if (active) begin
        if (divLast) begin
          divCnt <= '0;
          phase  <= ~phase;
          if (phase) begin
            shiftReg <= shiftReg << 1;
            if (done) begin
              active <= 1'b0;
              bitCnt <= '0;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
        end else begin
          divCnt <= divCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iagc_dac_init.sv
// rtl/iagc_dac_init.sv - DAC power-up sequencer: shifts the init table out, then holds sticky done
module iagc_dac_init
  import iagc_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_WORDS  = 3,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  iagc_dac_init_if.master  dac,
  output logic             o_busy,
  output logic             o_initDone
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  dacState_t             state;
  dacState_t             nextState;
  logic [IDX_W-1:0]      wordIdx;
  logic [IDX_W-1:0]      nextIdx;
  logic [GAP_W-1:0]      gapCnt;
  logic [GAP_W-1:0]      nextGap;
  logic                  txLoad;
  logic                  txBusy;
  logic                  txDone;
  logic [WORD_WIDTH-1:0] txWord;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      wordIdx    <= '0;
      gapCnt     <= '0;
      dac.csN    <= 1'b1;
      o_busy     <= 1'b0;
      o_initDone <= 1'b0;
    end else begin
      state      <= nextState;
      wordIdx    <= nextIdx;
      gapCnt     <= nextGap;
      // follows the serialiser with one clock of delay to line up with its registered sclk/mosi
      dac.csN    <= ~txBusy;
      o_busy     <= (state == SHIFT) || (state == GAP);
      o_initDone <= (state == DONE);
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = wordIdx;
    nextGap   = gapCnt;
    txLoad    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          nextState = SHIFT;
          nextIdx   = '0;
          txLoad    = 1'b1;
        end
      end
      SHIFT: begin
        if (txDone) begin
          nextGap   = '0;
          nextState = (wordIdx == LAST_IDX) ? DONE : GAP;
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST) begin
          nextState = SHIFT;
          nextIdx   = wordIdx + 1'b1;
          txLoad    = 1'b1;
        end else begin
          nextGap = gapCnt + 1'b1;
        end
      end
      DONE: begin
        nextState = DONE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign txWord = WORD_WIDTH'(dacInitWord(int'(nextIdx)));

  iagc_spi_tx #(
    .WORD_WIDTH (WORD_WIDTH),
    .CLK_DIV    (CLK_DIV)
  ) u_spiTx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .load    (txLoad),
    .word    (txWord),
    .busy    (txBusy),
    .done    (txDone),
    .sclk    (dac.sclk),
    .mosi    (dac.mosi)
  );

endmodule

// File: tb/tb_iagc_dac_init.sv
// tb/tb_iagc_dac_init.sv - scoreboard bench for the DAC init sequencer, default and minimal parameters
module tb_iagc_dac_init;

  typedef struct {
    logic [15:0] word;
    int          rises;
    int          low;
  } cap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic rst2 = 1'b1;
  logic start2 = 1'b0;
  logic busy2;
  logic done2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fallCyc = 0;
  int doneCyc = 0;

  logic [15:0] expQ[$];
  cap_t        capQ[$];
  int          gapQ[$];

  logic [15:0] monAcc;
  int          monRises;
  int          monLow;
  int          monHigh;
  logic        monSeenRise;
  logic        monPrevCs;
  logic        monPrevSclk;

  iagc_dac_init_if dacA ();
  iagc_dac_init_if dacB ();

  iagc_dac_init dutA (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .dac        (dacA),
    .o_busy     (busy),
    .o_initDone (done)
  );

  iagc_dac_init #(
    .WORD_WIDTH (16),
    .NUM_WORDS  (1),
    .CLK_DIV    (1),
    .GAP_CYCLES (1)
  ) dutB (
    .i_clock    (clk),
    .i_reset    (rst2),
    .i_start    (start2),
    .dac        (dacB),
    .o_busy     (busy2),
    .o_initDone (done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // serial-link monitor for dutA: captures words on sclk rises and times the gaps
  always @(negedge clk) begin
    if (rst) begin
      monAcc = '0; monRises = 0; monLow = 0; monHigh = 0;
      monSeenRise = 1'b0; monPrevCs = 1'b1; monPrevSclk = 1'b0;
    end else begin
      if (dacA.csN === 1'b0) begin
        if (monPrevCs && monSeenRise) gapQ.push_back(monHigh);
        monLow = monLow + 1;
        if (dacA.sclk === 1'b1 && monPrevSclk === 1'b0) begin
          monAcc   = {monAcc[14:0], dacA.mosi};
          monRises = monRises + 1;
        end
      end else begin
        if (!monPrevCs) begin
          capQ.push_back('{monAcc, monRises, monLow});
          monSeenRise = 1'b1;
          monHigh = 0; monAcc = '0; monRises = 0; monLow = 0;
        end
        monHigh = monHigh + 1;
      end
      monPrevCs   = dacA.csN;
      monPrevSclk = dacA.sclk;
    end
  end

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({dacA.csN, dacA.sclk, busy, done} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: csN,sclk,busy,done=%b required 1000", i,
                 {dacA.csN, dacA.sclk, busy, done});
      end
    end
  endtask

  task automatic test_start_latency();
    logic [15:0] w;
    expQ.push_back(16'h2001);
    expQ.push_back(16'h3FFF);
    expQ.push_back(16'h4A55);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({dacA.csN, busy} !== 2'b10) begin
      errors++;
      $display("FAIL start_edge_k: csN,busy=%b required 10", {dacA.csN, busy});
    end
    @(negedge clk);
    fallCyc = cyc;
    w = expQ[0];
    checks++;
    if ({dacA.csN, busy} !== 2'b01) begin
      errors++;
      $display("FAIL start_edge_k1: csN,busy=%b required 01", {dacA.csN, busy});
    end
    checks++;
    if (dacA.mosi !== w[15]) begin
      errors++;
      $display("FAIL start_first_bit: mosi=%b required %b", dacA.mosi, w[15]);
    end
    checks++;
    if (dacA.sclk !== 1'b0) begin
      errors++;
      $display("FAIL start_sclk_k1: sclk=%b required 0", dacA.sclk);
    end
    @(negedge clk);
    checks++;
    if (dacA.sclk !== 1'b0) begin
      errors++;
      $display("FAIL start_sclk_k2: sclk=%b required 0", dacA.sclk);
    end
    @(negedge clk);
    checks++;
    if (dacA.sclk !== 1'b1) begin
      errors++;
      $display("FAIL start_sclk_rise_k3: sclk=%b required 1", dacA.sclk);
    end
  endtask

  task automatic test_full_sequence();
    logic  doneSeen = 1'b0;
    logic  pulsed = 1'b0;
    cap_t  c;
    logic [15:0] e;
    int    g;
    for (int i = 0; i < 1000 && !doneSeen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!pulsed && capQ.size() == 1 && dacA.csN === 1'b0) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (done === 1'b1) begin
        doneSeen = 1'b1;
        doneCyc = cyc;
      end
    end
    start = 1'b0;
    checks++;
    if (!doneSeen) begin
      errors++;
      $display("FAIL seq_done_timeout: initDone=%b required 1", done);
    end
    checks++;
    if (doneCyc - fallCyc !== 200) begin
      errors++;
      $display("FAIL seq_latency: clocks=%0d required 200", doneCyc - fallCyc);
    end
    @(negedge clk);
    checks++;
    if (capQ.size() !== 3) begin
      errors++;
      $display("FAIL seq_word_count: words=%0d required 3", capQ.size());
    end
    while (capQ.size() > 0 && expQ.size() > 0) begin
      c = capQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (c.word !== e) begin
        errors++;
        $display("FAIL seq_word: got %h required %h", c.word, e);
      end
      checks++;
      if (c.rises !== 16) begin
        errors++;
        $display("FAIL seq_rises: got %0d required 16", c.rises);
      end
      checks++;
      if (c.low !== 64) begin
        errors++;
        $display("FAIL seq_low_clocks: got %0d required 64", c.low);
      end
    end
    checks++;
    if (gapQ.size() !== 2) begin
      errors++;
      $display("FAIL seq_gap_count: gaps=%0d required 2", gapQ.size());
    end
    while (gapQ.size() > 0) begin
      g = gapQ.pop_front();
      checks++;
      if (g !== 4) begin
        errors++;
        $display("FAIL seq_gap_len: got %0d required 4", g);
      end
    end
  endtask

  task automatic test_ignore_after_done();
    capQ.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if ({dacA.csN, busy, done} !== 3'b101) begin
        errors++;
        $display("FAIL done_hold cycle %0d: csN,busy,initDone=%b required 101", i,
                 {dacA.csN, busy, done});
      end
    end
    checks++;
    if (capQ.size() !== 0) begin
      errors++;
      $display("FAIL done_no_restart: words=%0d required 0", capQ.size());
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    cap_t c;
    logic [15:0] e;
    expQ.delete(); capQ.delete(); gapQ.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expQ.push_back(16'h2001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (capQ.size() == 1 && monRises == 7 && dacA.csN === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach_bit7: reached=%b required 1", found);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dacA.csN, dacA.sclk, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_outputs: csN,sclk,busy,initDone=%b required 1000",
               {dacA.csN, dacA.sclk, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (capQ.size() !== 1) begin
      errors++;
      $display("FAIL mid_partial_discard: words=%0d required 1", capQ.size());
    end
    if (capQ.size() > 0 && expQ.size() > 0) begin
      c = capQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (c.word !== e) begin
        errors++;
        $display("FAIL mid_first_word: got %h required %h", c.word, e);
      end
    end
    capQ.delete(); expQ.delete();
    expQ.push_back(16'h2001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && capQ.size() == 0; i++) @(negedge clk);
    checks++;
    if (capQ.size() == 0) begin
      errors++;
      $display("FAIL restart_timeout: words=0 required 1");
    end else begin
      c = capQ.pop_front();
      e = expQ.pop_front();
      if (c.word !== e) begin
        errors++;
        $display("FAIL restart_word: got %h required %h", c.word, e);
      end
    end
    for (int i = 0; i < 1000 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: initDone=%b required 1", done);
    end
  endtask

  task automatic test_param_sweep();
    int          low = 0;
    int          rises = 0;
    logic [15:0] w = '0;
    logic        prevS = 1'b0;
    logic        fin = 1'b0;
    logic        doneAtRise = 1'b0;
    logic        earlyDone = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (dacB.csN === 1'b0) begin
        low++;
        if (done2 === 1'b1) earlyDone = 1'b1;
        if (dacB.sclk === 1'b1 && prevS === 1'b0) begin
          w = {w[14:0], dacB.mosi};
          rises++;
        end
      end else if (low > 0) begin
        fin = 1'b1;
        doneAtRise = done2;
      end
      prevS = dacB.sclk;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL sweep_timeout: finished=%b required 1", fin);
    end
    checks++;
    if (low !== 32) begin
      errors++;
      $display("FAIL sweep_low_clocks: got %0d required 32", low);
    end
    checks++;
    if (rises !== 16) begin
      errors++;
      $display("FAIL sweep_rises: got %0d required 16", rises);
    end
    checks++;
    if (w !== 16'h2001) begin
      errors++;
      $display("FAIL sweep_word: got %h required 2001", w);
    end
    checks++;
    if (doneAtRise !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done_at_cs_rise: initDone=%b required 1", doneAtRise);
    end
    checks++;
    if (earlyDone !== 1'b0) begin
      errors++;
      $display("FAIL sweep_early_done: seen=%b required 0", earlyDone);
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_full_sequence();
    test_ignore_after_done();
    test_reset_mid();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
